pack: RTL and testbench

PACK -- requirements
Module: pack

---
 rtl/pack.sv | 64 ++++++
 tb/tb_pack.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/pack.sv
// Width up-converter: gathers D narrow lanes of W bits into one packed word,
// closing early on s_lst. One-cycle latency, single output register with backpressure.
module pack #(
    parameter int W = 8,
    parameter int D = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_stb,
    input  logic [W-1:0]         s_dat,
    input  logic                 s_lst,
    output logic                 s_rdy,
    input  logic                 m_rdy,
    output logic                 m_stb,
    output logic [W*D-1:0]       m_dat,
    output logic                 m_lst,
    output logic [$clog2(D):0]   m_cnt
);
    localparam int IW = $clog2(D);

    logic [IW-1:0]  idx;
    logic [W*D-1:0] acc;
    logic [W*D-1:0] merged;
    logic           take;
    logic           done;

    assign s_rdy = !m_stb | m_rdy;
    assign take  = s_stb & s_rdy;
    assign done  = take & ((idx == IW'(D - 1)) | s_lst);

    // Lanes above idx are always zero in acc, so the merge doubles as the zero-fill.
    always_comb begin
        merged = acc;
        for (int k = 0; k < D; k++) begin
            if (idx == IW'(k)) merged[W*k +: W] = s_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx   <= '0;
            acc   <= '0;
            m_stb <= 1'b0;
            m_dat <= '0;
            m_lst <= 1'b0;
            m_cnt <= '0;
        end else begin
            if (m_stb & m_rdy) m_stb <= 1'b0;
            if (take) begin
                if (done) begin
                    m_dat <= merged;
                    m_stb <= 1'b1;
                    m_lst <= s_lst;
                    m_cnt <= {1'b0, idx} + 1'b1;
                    idx   <= '0;
                    acc   <= '0;
                end else begin
                    acc <= merged;
                    idx <= idx + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_pack.sv
// Bench for pack (W=8, D=4): vector table with hand-derived packed results fed
// through a scoreboard queue, plus timed sequences for reset, backpressure and streaming.
module tb_pack;
    localparam int W = 8;
    localparam int D = 4;

    typedef struct {
        logic [7:0]  dat;
        logic        lst;
        logic        ev;
        logic [31:0] edat;
        logic [2:0]  ecnt;
        logic        elst;
    } vec_t;

    typedef struct {
        logic [31:0] dat;
        logic [2:0]  cnt;
        logic        lst;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_stb = 1'b0;
    logic [7:0]  s_dat = '0;
    logic        s_lst = 1'b0;
    logic        s_rdy;
    logic        m_rdy = 1'b1;
    logic        m_stb;
    logic [31:0] m_dat;
    logic        m_lst;
    logic [2:0]  m_cnt;

    vec_t tbl[35];
    exp_t sb[$];
    exp_t mon_e;
    int   pop_cyc[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;

    pack #(.W(W), .D(D)) dut (
        .clk(clk), .rst(rst),
        .s_stb(s_stb), .s_dat(s_dat), .s_lst(s_lst), .s_rdy(s_rdy),
        .m_rdy(m_rdy), .m_stb(m_stb), .m_dat(m_dat), .m_lst(m_lst), .m_cnt(m_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Every output handshake pops one expected word.
    always @(negedge clk) begin
        if (!rst && m_stb && m_rdy) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL unexpected_word: got %h expected none", m_dat);
            end else begin
                mon_e = sb.pop_front();
                check("m_dat", m_dat, mon_e.dat);
                check("m_cnt", 32'(m_cnt), 32'(mon_e.cnt));
                check("m_lst", 32'(m_lst), 32'(mon_e.lst));
                pop_cyc.push_back(cyc);
            end
        end
    end

    task automatic put(input int i, input logic [7:0] d, input logic l, input logic ev,
                       input logic [31:0] ed, input logic [2:0] ec, input logic el);
        tbl[i].dat = d; tbl[i].lst = l; tbl[i].ev = ev;
        tbl[i].edat = ed; tbl[i].ecnt = ec; tbl[i].elst = el;
    endtask

    // Drive vector i from posedge+1 until accepted; w = cycles spent waiting.
    task automatic send(input int i, output int w);
        bit fin;
        exp_t e;
        s_stb = 1'b1; s_dat = tbl[i].dat; s_lst = tbl[i].lst;
        w = 0;
        fin = 0;
        while (!fin) begin
            @(negedge clk);
            if (s_rdy) begin
                if (tbl[i].ev) begin
                    e.dat = tbl[i].edat; e.cnt = tbl[i].ecnt; e.lst = tbl[i].elst;
                    sb.push_back(e);
                end
                fin = 1;
            end else begin
                w++;
                if (w > 50) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL accept_timeout vec %0d: s_rdy=%b expected 1", i, s_rdy);
                    fin = 1;
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic idle(input int n);
        s_stb = 1'b0; s_lst = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int w;
        int sum;
        put(0, 8'h11, 0, 0, 0, 0, 0);
        put(1, 8'h22, 0, 0, 0, 0, 0);
        put(2, 8'h33, 0, 0, 0, 0, 0);
        put(3, 8'h44, 0, 1, 32'h44332211, 3'd4, 0);
        put(4, 8'h55, 0, 0, 0, 0, 0);
        put(5, 8'h66, 0, 0, 0, 0, 0);
        put(6, 8'h77, 0, 0, 0, 0, 0);
        put(7, 8'h88, 0, 1, 32'h88776655, 3'd4, 0);
        put(8, 8'h99, 0, 0, 0, 0, 0);
        put(9, 8'hAB, 1, 1, 32'h0000AB99, 3'd2, 1);
        put(10, 8'hAA, 0, 0, 0, 0, 0);
        put(11, 8'hBB, 1, 1, 32'h0000BBAA, 3'd2, 1);
        put(12, 8'hC1, 0, 0, 0, 0, 0);
        put(13, 8'hC2, 0, 0, 0, 0, 0);
        put(14, 8'hC3, 0, 0, 0, 0, 0);
        put(15, 8'hC4, 0, 1, 32'hC4C3C2C1, 3'd4, 0);
        put(16, 8'hD1, 0, 0, 0, 0, 0);
        put(17, 8'hD2, 0, 0, 0, 0, 0);
        put(18, 8'hD3, 0, 0, 0, 0, 0);
        put(19, 8'hD4, 1, 1, 32'hD4D3D2D1, 3'd4, 1);
        put(20, 8'hE5, 1, 1, 32'h000000E5, 3'd1, 1);
        for (int i = 0; i < 8; i++)
            put(21 + i, 8'(i + 1), 0, (i == 3 || i == 7), (i == 3) ? 32'h04030201 : 32'h08070605, 3'd4, 0);
        put(29, 8'hDE, 0, 0, 0, 0, 0);
        put(30, 8'hAD, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++)
            put(31 + i, 8'(i + 1), 0, (i == 3), 32'h04030201, 3'd4, 0);

        // Reset held for two edges.
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_m_stb", 32'(m_stb), 0);
        check("rst_m_lst", 32'(m_lst), 0);
        check("rst_m_cnt", 32'(m_cnt), 0);
        check("rst_m_dat", m_dat, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_s_rdy", 32'(s_rdy), 1);
        @(posedge clk); #1;

        // Back-to-back packet, output held exactly one cycle.
        for (int i = 0; i <= 3; i++) send(i, w);
        s_stb = 1'b0;
        @(negedge clk);
        check("b2b_stb_on", 32'(m_stb), 1);
        @(posedge clk); #1;
        @(negedge clk);
        check("b2b_stb_off", 32'(m_stb), 0);
        idle(2);

        // Backpressure: stall 5 cycles with a pending input word.
        m_rdy = 1'b0;
        for (int i = 4; i <= 7; i++) send(i, w);
        s_stb = 1'b1; s_dat = 8'h99; s_lst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_s_rdy", 32'(s_rdy), 0);
            check("bp_m_stb", 32'(m_stb), 1);
            check("bp_m_dat", m_dat, 32'h88776655);
            @(posedge clk); #1;
        end
        m_rdy = 1'b1;
        send(8, w);
        check("bp_same_cycle", 32'(w), 0);
        send(9, w);
        idle(2);

        // Short packets, full packet ending in s_lst, single-word packet.
        for (int i = 10; i <= 20; i++) send(i, w);
        idle(2);

        // Streaming: one packed word per four inputs, no stalls.
        sum = 0;
        for (int i = 21; i <= 28; i++) begin
            send(i, w);
            sum += w;
        end
        idle(2);
        check("stream_s_rdy_waits", 32'(sum), 0);
        if (pop_cyc.size() >= 2)
            check("stream_spacing", 32'(pop_cyc[$] - pop_cyc[$-1]), 4);
        else
            check("stream_pops", 32'(pop_cyc.size()), 2);

        // Reset mid-word discards partial lanes.
        send(29, w);
        send(30, w);
        s_stb = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_s_rdy", 32'(s_rdy), 1);
        check("mid_rst_m_stb", 32'(m_stb), 0);
        @(posedge clk); #1;
        for (int i = 31; i <= 34; i++) send(i, w);
        idle(3);

        check("sb_drained", 32'(sb.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end
endmodule
